transition_timer_display: RTL and testbench
===========================================

# transition_timer_display

Monitors the 4-bit state output of the button-driven state machine and drives a 4-digit multiplexed seven-segment display. The display shows the current state, the previous state, and the whole seconds elapsed since the last state transition. The block sits between the state machine's `STATE_OUT` and the board display pins, and also emits a one-cycle transition strobe for other consumers.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per one-second tick (≥2).
- `REFRESH_DIV`, default 100_000: clock cycles per digit-scan step (≥2).
- `CLK` in, 1: system clock; all logic on the rising edge.
- `RESET` in, 1: reset is synchronous and active-high; one clock only.
- `STATE_IN` in, 4: state code from the state machine. Synchronous to `CLK`.
- `TRANSITION_OUT` out, 1: one-cycle pulse on every detected state change.
- `SEG_SELECT_OUT` out, 4: digit anode select, active-low one-hot.
- `HEX_OUT` out, 8: {DP, g, f, e, d, c, b, a}, active-low.

## Operation
- Registers:
  - `cur_q` and `prev_q` (4 bits each).
  - Seconds count as two BCD digits, `sec_tens` and `sec_units`.
  - Tick prescaler, 0..TICK_DIV-1.
  - Refresh prescaler, 0..REFRESH_DIV-1.
  - 2-bit digit index.
- Transition detect: on any edge where `STATE_IN != cur_q`:
  - `prev_q <= cur_q`, `cur_q <= STATE_IN`.
  - Seconds cleared to 00 and tick prescaler cleared to 0.
  - `TRANSITION_OUT <= 1`.
  - Otherwise `TRANSITION_OUT <= 0`.
- Seconds: when the tick prescaler reaches TICK_DIV-1, it wraps to 0 and the BCD count increments.
  - Units 9 → 0 with tens +1.
  - The count saturates at 99 and stays there until the next transition. The prescaler keeps running.
- Scan: when the refresh prescaler reaches REFRESH_DIV-1, it wraps and the digit index increments 0→1→2→3→0.
- Digit mapping:
  - 0 = `sec_units`, select 4'b1110.
  - 1 = `sec_tens`, select 4'b1101.
  - 2 = `prev_q`, select 4'b1011.
  - 3 = `cur_q`, select 4'b0111.
- Decode: full hex 0–F. Codes {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- DP is lit (0) only on digit 2, which separates the state pair from the timer. DP is 1 on all other digits.

## Timing
- Reset values:
  - `cur_q`=0, `prev_q`=0, seconds=00, both prescalers=0, digit index=0.
  - `TRANSITION_OUT`=0, `SEG_SELECT_OUT`=4'b1110, `HEX_OUT`=8'hC0.
- Transition latency:
  - `STATE_IN` changes before edge k. At edge k, `cur_q` and `prev_q` update and `TRANSITION_OUT` rises. At edge k+1, `TRANSITION_OUT` falls.
  - `SEG_SELECT_OUT` and `HEX_OUT` are registered from the mux of registered values. They reflect updated `cur_q`/`prev_q`/seconds at edge k+1 whenever the relevant digit is selected.
- A nonzero `STATE_IN` held through reset produces a transition on the first edge after reset (previous = 0).
- State changes on consecutive cycles: each change pulses `TRANSITION_OUT`, so the pulse stays high continuously. `prev_q` always holds the value immediately before the latest change.
- `STATE_IN` returning to an earlier value is still a transition.
- Transition and tick on the same edge: transition wins; seconds=00 and prescaler=0.
- Transition and scan step on the same edge: both take effect independently.
- Scan index and selected digit change together at the next output register edge. `SEG_SELECT_OUT` and `HEX_OUT` never disagree for a cycle.
- `RESET` mid-count or mid-scan returns all registers to reset values at that edge.

## Structure
- Package `display_pkg` holds:
  - Active-low seven-segment code constants for 0–F.
  - DP bit position.
  - Digit select constants DIG0..DIG3 (4'b1110..4'b0111).
  - Digit index typedef (2-bit).
- Sub-module `seg7_decoder`: 4-bit value in, 7-bit active-low {g..a} out, purely combinational, using package constants.
- Prescaler widths are `$clog2(TICK_DIV)` and `$clog2(REFRESH_DIV)`.

## Test plan
All scenarios use TICK_DIV=10 and REFRESH_DIV=4.
- Reset, then hold `STATE_IN`=0 → `TRANSITION_OUT` stays 0; `SEG_SELECT_OUT`=1110 and `HEX_OUT`=C0. After 4 cycles, select=1101 with `HEX_OUT`=C0.
- `STATE_IN` 0→6 → a single `TRANSITION_OUT` pulse. Digit 3 shows 82; digit 2 shows 40 (0 with DP lit).
- Hold `STATE_IN` for 125 cycles after a transition → digits 1/0 read 1/2 (`HEX_OUT` F9/A4). After 1000+ cycles they read 9/9 (90/90) and stay there.
- `STATE_IN` 6→2 on the same edge as a tick terminal count → seconds=00, digit 2 shows 02 (6 with DP), digit 3 shows A4.
- `STATE_IN` 1, 5, 3 on consecutive cycles → `TRANSITION_OUT` high for 3 cycles; final `cur_q`=3 and `prev_q`=5.
- Assert `RESET` for one cycle mid-count at seconds=07 → next cycle: all outputs at reset values. With `STATE_IN`≠0, one transition pulse follows.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the transition timer display: segment codes, digit selects, index type.
// Latency: none (definitions only).
// Backpressure: not applicable.
package display_pkg;

    // Active-low {g,f,e,d,c,b,a} codes for hex digits 0-F
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam int DP_BIT = 7;

    localparam logic [3:0] DIG0 = 4'b1110;
    localparam logic [3:0] DIG1 = 4'b1101;
    localparam logic [3:0] DIG2 = 4'b1011;
    localparam logic [3:0] DIG3 = 4'b0111;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low seven-segment {g..a} pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (value)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/transition_timer_display.sv
// Shows current state, previous state and seconds since last change on a 4-digit mux display.
// Latency: transition strobe 1 cycle after STATE_IN changes; display outputs 1 register behind internal state.
// Backpressure: none; free-running, every input cycle is consumed.
module transition_timer_display
    import display_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] STATE_IN,
    output logic       TRANSITION_OUT,
    output logic [3:0] SEG_SELECT_OUT,
    output logic [7:0] HEX_OUT
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

    logic [3:0]        cur_q;
    logic [3:0]        prev_q;
    logic [3:0]        sec_tens;
    logic [3:0]        sec_units;
    logic [TICK_W-1:0] tick_cnt;
    logic [REF_W-1:0]  ref_cnt;
    digit_idx_t        dig_idx;

    logic       state_change;
    logic       sec_at_max;
    logic [3:0] disp_val;
    logic [3:0] disp_sel;
    logic       disp_dp_n;
    logic [6:0] disp_seg;
    logic [7:0] hex_nxt;

    assign state_change = (STATE_IN != cur_q);
    assign sec_at_max   = (sec_tens == BCD_MAX) && (sec_units == BCD_MAX);

    // State capture and elapsed-seconds counter; a change restarts the second boundary
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur_q          <= 4'd0;
            prev_q         <= 4'd0;
            sec_tens       <= 4'd0;
            sec_units      <= 4'd0;
            tick_cnt       <= '0;
            TRANSITION_OUT <= 1'b0;
        end else if (state_change) begin
            prev_q         <= cur_q;
            cur_q          <= STATE_IN;
            sec_tens       <= 4'd0;
            sec_units      <= 4'd0;
            tick_cnt       <= '0;
            TRANSITION_OUT <= 1'b1;
        end else begin
            TRANSITION_OUT <= 1'b0;
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (!sec_at_max) begin
                    if (sec_units == BCD_MAX) begin
                        sec_units <= 4'd0;
                        sec_tens  <= sec_tens + 4'd1;
                    end else begin
                        sec_units <= sec_units + 4'd1;
                    end
                end
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ref_cnt <= '0;
            dig_idx <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            dig_idx <= dig_idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    // Decimal point marks digit 2, splitting the state pair from the timer
    always_comb begin
        disp_val  = sec_units;
        disp_sel  = DIG0;
        disp_dp_n = 1'b1;
        case (dig_idx)
            2'd0: begin
                disp_val = sec_units;
                disp_sel = DIG0;
            end
            2'd1: begin
                disp_val = sec_tens;
                disp_sel = DIG1;
            end
            2'd2: begin
                disp_val  = prev_q;
                disp_sel  = DIG2;
                disp_dp_n = 1'b0;
            end
            default: begin
                disp_val = cur_q;
                disp_sel = DIG3;
            end
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .value (disp_val),
        .seg   (disp_seg)
    );

    always_comb begin
        hex_nxt         = {1'b1, disp_seg};
        hex_nxt[DP_BIT] = disp_dp_n;
    end

    // Select and pattern share one register so they always switch together
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SEG_SELECT_OUT <= DIG0;
            HEX_OUT        <= {1'b1, SEG_0};
        end else begin
            SEG_SELECT_OUT <= disp_sel;
            HEX_OUT        <= hex_nxt;
        end
    end

endmodule

// File: tb/tb_transition_timer_display.sv
// Randomised and scenario-driven bench for transition_timer_display against an elapsed-time model.
module tb_transition_timer_display;

    localparam int TICK_DIV    = 10;
    localparam int REFRESH_DIV = 4;

    logic       CLK;
    logic       RESET;
    logic [3:0] STATE_IN;
    logic       TRANSITION_OUT;
    logic [3:0] SEG_SELECT_OUT;
    logic [7:0] HEX_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges since reset, edges since last transition/reset
    int         m_age;
    int         m_since;
    logic [3:0] m_cur;
    logic [3:0] m_prev;
    logic       exp_trans;
    logic [3:0] exp_sel;
    logic [7:0] exp_hex;

    logic [6:0] seg_tbl [16];

    transition_timer_display #(
        .TICK_DIV    (TICK_DIV),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .STATE_IN       (STATE_IN),
        .TRANSITION_OUT (TRANSITION_OUT),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .HEX_OUT        (HEX_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int seconds_shown();
        int s;
        s = m_since / TICK_DIV;
        if (s > 99) s = 99;
        return s;
    endfunction

    // What the display should show for the model state as it stands
    task automatic model_display(output logic [3:0] sel, output logic [7:0] hex);
        int idx;
        int s;
        logic [3:0] v;
        logic dp_n;
        idx  = (m_age / REFRESH_DIV) % 4;
        s    = seconds_shown();
        dp_n = 1'b1;
        case (idx)
            0: begin v = 4'(s % 10); sel = 4'b1110; end
            1: begin v = 4'(s / 10); sel = 4'b1101; end
            2: begin v = m_prev;     sel = 4'b1011; dp_n = 1'b0; end
            default: begin v = m_cur; sel = 4'b0111; end
        endcase
        hex = {dp_n, seg_tbl[v]};
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (RESET) begin
            exp_sel   = 4'b1110;
            exp_hex   = 8'hC0;
            exp_trans = 1'b0;
            m_age     = 0;
            m_since   = 0;
            m_cur     = 4'd0;
            m_prev    = 4'd0;
        end else begin
            model_display(exp_sel, exp_hex);
            m_age++;
            if (STATE_IN != m_cur) begin
                m_prev    = m_cur;
                m_cur     = STATE_IN;
                m_since   = 0;
                exp_trans = 1'b1;
            end else begin
                m_since++;
                exp_trans = 1'b0;
            end
        end
        #1;
        check_eq("transition", 32'(TRANSITION_OUT), 32'(exp_trans));
        check_eq("seg_select", 32'(SEG_SELECT_OUT), 32'(exp_sel));
        check_eq("hex",        32'(HEX_OUT),        32'(exp_hex));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
        seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
        seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
        seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
        seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
        seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
        seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
        seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;
        m_age = 0; m_since = 0; m_cur = 4'd0; m_prev = 4'd0;

        // Reset with idle state input
        RESET    = 1'b1;
        STATE_IN = 4'd0;
        cycle();
        check_eq("reset_sel", 32'(SEG_SELECT_OUT), 32'h0000000E);
        check_eq("reset_hex", 32'(HEX_OUT),        32'h000000C0);
        RESET = 1'b0;
        run(12);

        // First transition, then let seconds build up and saturate
        STATE_IN = 4'd6;
        run(20);
        run(110);
        check_eq("secs_12", 32'(seconds_shown()), 32'd12);
        run(1000);
        check_eq("secs_sat", 32'(seconds_shown()), 32'd99);
        run(40);

        // Transition landing on a tick terminal count
        for (int i = 0; i < TICK_DIV && (m_since % TICK_DIV) != TICK_DIV - 1; i++) cycle();
        check_eq("tick_align", 32'(m_since % TICK_DIV), 32'(TICK_DIV - 1));
        STATE_IN = 4'd2;
        run(20);

        // Back-to-back changes, including a return to an earlier value
        STATE_IN = 4'd1; cycle();
        STATE_IN = 4'd5; cycle();
        STATE_IN = 4'd3; cycle();
        check_eq("prev_after_burst", 32'(m_prev), 32'd5);
        run(20);
        STATE_IN = 4'd5;
        run(16);

        // Reset mid-count at seven seconds with a nonzero state held
        for (int i = 0; i < 200 && seconds_shown() != 7; i++) cycle();
        check_eq("secs_7", 32'(seconds_shown()), 32'd7);
        RESET    = 1'b1;
        STATE_IN = 4'd9;
        cycle();
        RESET = 1'b0;
        run(20);

        // Random state changes with occasional reset
        for (int i = 0; i < 600; i++) begin
            RESET = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) STATE_IN = 4'($urandom_range(0, 15));
            cycle();
        end
        RESET = 1'b0;
        run(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
